cpu_bus_arbiter: RTL

Two-port arbiter that shares the single CPU memory bus between the data cache (port 0) and the instruction cache (port 1). Each port speaks the same level-request / ready-pulse protocol the caches use towards the bus, and the arbiter owns the downstream bus outputs as registers. Data accesses have priority. A starvation counter guarantees the instruction port a grant after a bounded number of consecutive data-port wins.

---
 rtl/cpu_bus_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// Shares the single CPU memory bus between the data cache (port 0) and the
// instruction cache (port 1). Data accesses have priority, and a starvation
// counter forces an instruction grant after STARVE_LIMIT consecutive data wins.
//
// Ports:
//   i_clock, i_reset            clock; synchronous active-high reset
//   i_px_request/rw/address/wdata/wmask   level request from cache x, held until o_px_ready
//   o_px_ready, o_px_rdata      one-cycle completion pulse; read data held afterwards
//   o_bus_*                     registered downstream request fields
//   i_bus_ready, i_bus_rdata    downstream completion and read data
module cpu_bus_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_p0_rw,
  input  logic        i_p1_rw,
  input  logic        i_p0_request,
  input  logic        i_p1_request,
  output logic        o_p0_ready,
  output logic        o_p1_ready,
  input  logic [31:0] i_p0_address,
  input  logic [31:0] i_p1_address,
  output logic [31:0] o_p0_rdata,
  output logic [31:0] o_p1_rdata,
  input  logic [31:0] i_p0_wdata,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p0_wmask,
  input  logic [3:0]  i_p1_wmask,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    GRANT0  = 4'b0010,
    GRANT1  = 4'b0100,
    RELEASE = 4'b1000
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;

  logic        bus_rw_nxt, bus_request_nxt;
  logic [31:0] bus_address_nxt, bus_wdata_nxt;
  logic [3:0]  bus_wmask_nxt;
  logic        p0_ready_nxt, p1_ready_nxt;
  logic [31:0] p0_rdata_nxt, p1_rdata_nxt;

  // Port 0 loses a contested arbitration only once port 1 has waited long enough.
  logic p0_wins;
  assign p0_wins = i_p0_request && !(i_p1_request && (starve_cnt >= LIMIT));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      o_bus_rw      <= 1'b0;
      o_bus_request <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_bus_wmask   <= '0;
      o_p0_ready    <= 1'b0;
      o_p1_ready    <= 1'b0;
      o_p0_rdata    <= '0;
      o_p1_rdata    <= '0;
    end else begin
      state         <= state_nxt;
      starve_cnt    <= starve_cnt_nxt;
      o_bus_rw      <= bus_rw_nxt;
      o_bus_request <= bus_request_nxt;
      o_bus_address <= bus_address_nxt;
      o_bus_wdata   <= bus_wdata_nxt;
      o_bus_wmask   <= bus_wmask_nxt;
      o_p0_ready    <= p0_ready_nxt;
      o_p1_ready    <= p1_ready_nxt;
      o_p0_rdata    <= p0_rdata_nxt;
      o_p1_rdata    <= p1_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    starve_cnt_nxt  = starve_cnt;
    bus_rw_nxt      = o_bus_rw;
    bus_request_nxt = o_bus_request;
    bus_address_nxt = o_bus_address;
    bus_wdata_nxt   = o_bus_wdata;
    bus_wmask_nxt   = o_bus_wmask;
    p0_ready_nxt    = 1'b0;
    p1_ready_nxt    = 1'b0;
    p0_rdata_nxt    = o_p0_rdata;
    p1_rdata_nxt    = o_p1_rdata;

    case (state)
      IDLE: begin
        if (p0_wins) begin
          bus_rw_nxt      = i_p0_rw;
          bus_address_nxt = i_p0_address;
          bus_wdata_nxt   = i_p0_wdata;
          bus_wmask_nxt   = i_p0_wmask;
          bus_request_nxt = 1'b1;
          state_nxt       = GRANT0;
          if (i_p1_request && (starve_cnt < LIMIT))
            starve_cnt_nxt = starve_cnt + 1'b1;
        end else if (i_p1_request) begin
          bus_rw_nxt      = i_p1_rw;
          bus_address_nxt = i_p1_address;
          bus_wdata_nxt   = i_p1_wdata;
          bus_wmask_nxt   = i_p1_wmask;
          bus_request_nxt = 1'b1;
          state_nxt       = GRANT1;
          starve_cnt_nxt  = '0;
        end
      end
      // Read data is captured for writes too; the cache ignores it.
      GRANT0: begin
        if (i_bus_ready) begin
          bus_request_nxt = 1'b0;
          p0_rdata_nxt    = i_bus_rdata;
          p0_ready_nxt    = 1'b1;
          state_nxt       = RELEASE;
        end
      end
      GRANT1: begin
        if (i_bus_ready) begin
          bus_request_nxt = 1'b0;
          p1_rdata_nxt    = i_bus_rdata;
          p1_ready_nxt    = 1'b1;
          state_nxt       = RELEASE;
        end
      end
      // One dead cycle so the finished requester can drop its level request.
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
